// File: rtl/gpio_defs.sv
// Shared register-map definitions for the iomem GPIO block.
// Word offsets within the 32-byte register window, plus a byte-strobe expander.
package gpio_defs;

  localparam int GPIO_OFS_W = 3;
  typedef logic [GPIO_OFS_W-1:0] gpio_ofs_t;

  localparam gpio_ofs_t GPIO_OUT    = 3'd0;
  localparam gpio_ofs_t GPIO_OE     = 3'd1;
  localparam gpio_ofs_t GPIO_IN     = 3'd2;
  localparam gpio_ofs_t GPIO_RISE   = 3'd3;
  localparam gpio_ofs_t GPIO_FALL   = 3'd4;
  localparam gpio_ofs_t GPIO_STATUS = 3'd5;
  localparam gpio_ofs_t GPIO_SET    = 3'd6;
  localparam gpio_ofs_t GPIO_CLR    = 3'd7;

  function automatic logic [31:0] strb_mask(input logic [3:0] wstrb);
    return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser chain followed by a one-cycle delay flop for edge detection.
// s is the last sync stage; rise/fall compare it against the previous cycle.
module gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;

endmodule

// File: rtl/iomem_gpio.sv
// GPIO peripheral on the PicoSoC iomem bus: OUT/OE registers, synchronised inputs,
// atomic SET/CLR, and edge interrupts latched into a W1C STATUS register.
module iomem_gpio
  import gpio_defs::*;
#(
  parameter int         WIDTH       = 8,
  parameter logic [7:0] BASE_ADDR   = 8'h03,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_q, oe_q, rise_q, fall_q, status_q;
  logic [WIDTH-1:0] s, rise, fall, evt, w1c, wbits, wkeep;
  logic             hit, wr;
  gpio_ofs_t        ofs;
  logic [31:0]      bmask, rd_val;

  gpio_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clk     (clk),
    .resetn  (resetn),
    .gpio_in (gpio_in),
    .s       (s),
    .rise    (rise),
    .fall    (fall)
  );

  // Blocking on iomem_ready keeps a held valid from being acked twice in a row.
  assign hit   = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
  assign wr    = hit && (iomem_wstrb != 4'b0000);
  assign ofs   = iomem_addr[2 +: GPIO_OFS_W];
  assign bmask = strb_mask(iomem_wstrb);
  assign wbits = iomem_wdata[WIDTH-1:0] & bmask[WIDTH-1:0];
  assign wkeep = ~bmask[WIDTH-1:0];
  assign w1c   = (wr && ofs == GPIO_STATUS) ? wbits : '0;
  assign evt   = (rise & rise_q) | (fall & fall_q);

  always_comb begin
    rd_val = '0;
    case (ofs)
      GPIO_OUT:    rd_val[WIDTH-1:0] = out_q;
      GPIO_OE:     rd_val[WIDTH-1:0] = oe_q;
      GPIO_IN:     rd_val[WIDTH-1:0] = s;
      GPIO_RISE:   rd_val[WIDTH-1:0] = rise_q;
      GPIO_FALL:   rd_val[WIDTH-1:0] = fall_q;
      GPIO_STATUS: rd_val[WIDTH-1:0] = status_q;
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      out_q       <= '0;
      oe_q        <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      status_q    <= '0;
    end else begin
      iomem_ready <= hit;
      if (hit) iomem_rdata <= rd_val;
      // A new event outranks a same-cycle clear so no edge is ever lost.
      status_q <= (status_q & ~w1c) | evt;
      if (wr) begin
        case (ofs)
          GPIO_OUT:  out_q  <= (out_q & wkeep) | wbits;
          GPIO_OE:   oe_q   <= (oe_q & wkeep) | wbits;
          GPIO_RISE: rise_q <= (rise_q & wkeep) | wbits;
          GPIO_FALL: fall_q <= (fall_q & wkeep) | wbits;
          GPIO_SET:  out_q  <= out_q | wbits;
          GPIO_CLR:  out_q  <= out_q & ~wbits;
          default:   ;
        endcase
      end
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = oe_q;
  assign irq      = |status_q;

  logic unused_ok;
  assign unused_ok = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata, bmask};

endmodule

// File: tb/tb_iomem_gpio.sv
// Randomised and directed bench for iomem_gpio against an input-history reference model.
module tb_iomem_gpio;

  localparam int W    = 8;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         iomem_valid = 1'b0;
  logic         iomem_ready;
  logic [3:0]   iomem_wstrb = 4'h0;
  logic [31:0]  iomem_addr = 32'h0;
  logic [31:0]  iomem_wdata = 32'h0;
  logic [31:0]  iomem_rdata;
  logic [W-1:0] gpio_in = '0;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oe;
  logic         irq;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  iomem_gpio #(.WIDTH(W), .BASE_ADDR(8'h03), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_oe     (gpio_oe),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pin samples kept as a history, registers as plain variables.
  logic [W-1:0] m_out = '0, m_oe = '0, m_rise = '0, m_fall = '0, m_status = '0;
  logic         m_ready = 1'b0;
  logic [31:0]  m_rdata = '0;
  logic [W-1:0] hist [0:SYNC];

  initial for (int k = 0; k <= SYNC; k++) hist[k] = '0;

  function automatic logic [W-1:0] m_read(input int ofs);
    case (ofs)
      0: return m_out;
      1: return m_oe;
      2: return hist[SYNC-1];
      3: return m_rise;
      4: return m_fall;
      5: return m_status;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_out = '0; m_oe = '0; m_rise = '0; m_fall = '0; m_status = '0;
      m_ready = 1'b0; m_rdata = '0;
      for (int k = 0; k <= SYNC; k++) hist[k] = '0;
    end else begin
      logic [W-1:0] sv, pv, ev, wd, keep, clr;
      int ofs;
      sv   = hist[SYNC-1];
      pv   = hist[SYNC];
      ev   = (sv & ~pv & m_rise) | (~sv & pv & m_fall);
      wd   = iomem_wdata[W-1:0] & {W{iomem_wstrb[0]}};
      keep = ~{W{iomem_wstrb[0]}};
      clr  = '0;
      ofs  = int'(iomem_addr[4:2]);
      if (iomem_valid && !m_ready && iomem_addr[31:24] == 8'h03) begin
        m_rdata = 32'(m_read(ofs));
        m_ready = 1'b1;
        if (iomem_wstrb != 4'h0) begin
          case (ofs)
            0: m_out  = (m_out & keep) | wd;
            1: m_oe   = (m_oe & keep) | wd;
            3: m_rise = (m_rise & keep) | wd;
            4: m_fall = (m_fall & keep) | wd;
            5: clr    = wd;
            6: m_out  = m_out | wd;
            7: m_out  = m_out & ~wd;
            default: ;
          endcase
        end
      end else begin
        m_ready = 1'b0;
      end
      m_status = (m_status & ~clr) | ev;
      for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = gpio_in;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ready",    32'(iomem_ready), 32'(m_ready));
      check("rdata",    iomem_rdata,      m_rdata);
      check("gpio_out", 32'(gpio_out),    32'(m_out));
      check("gpio_oe",  32'(gpio_oe),     32'(m_oe));
      check("irq",      32'(irq),         32'(|m_status));
    end
  end

  task automatic bus(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d,
                     output logic [31:0] r);
    int n;
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = st; iomem_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!iomem_ready && n < 8);
    if (!iomem_ready) check("bus_timeout", 32'(iomem_ready), 32'd1);
    r = iomem_rdata;
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
  endtask

  task automatic wr(input int ofs, input logic [3:0] st, input logic [31:0] d);
    logic [31:0] r;
    bus(32'h0300_0000 | 32'(ofs * 4), st, d, r);
  endtask

  task automatic rd(input int ofs, output logic [31:0] r);
    bus(32'h0300_0000 | 32'(ofs * 4), 4'h0, 32'h0, r);
  endtask

  initial begin
    logic [31:0] r;
    int acks;

    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_ready", 32'(iomem_ready), 32'd0);
    check("rst_out",   32'(gpio_out),    32'd0);
    resetn = 1'b1;

    // Every offset reads zero out of reset.
    for (int o = 0; o < 8; o++) begin
      rd(o, r);
      check($sformatf("rst_rd%0d", o), r, 32'h0);
    end
    check("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    check("ready_one_cycle", 32'(iomem_ready), 32'd0);

    // Held valid: one ack every two cycles.
    iomem_valid = 1'b1; iomem_addr = 32'h0300_0000; iomem_wstrb = 4'h0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (iomem_ready) acks++;
    end
    iomem_valid = 1'b0;
    check("held_valid_acks", 32'(acks), 32'd3);

    // OUT byte write, then SET and CLR.
    wr(0, 4'b0001, 32'hFFFF_FFA5);
    check("out_a5", 32'(gpio_out), 32'hA5);
    wr(6, 4'hF, 32'h0A);
    check("set_af", 32'(gpio_out), 32'hAF);
    wr(7, 4'hF, 32'h81);
    check("clr_2e", 32'(gpio_out), 32'h2E);
    rd(0, r);
    check("out_rb", r, 32'h2E);
    rd(6, r);
    check("set_rd0", r, 32'h0);
    wr(0, 4'b0010, 32'h0000_00FF);
    check("out_strb_off", 32'(gpio_out), 32'h2E);

    // Input path latency.
    wr(1, 4'hF, 32'hFF);
    check("oe_ff", 32'(gpio_oe), 32'hFF);
    @(negedge clk);
    gpio_in = 8'h3C;
    rd(2, r);
    check("in_early", r, 32'h00);
    rd(2, r);
    check("in_3c", r, 32'h3C);

    // Edge interrupts: pin0 rises, pin1 falls.
    gpio_in = 8'h3E;
    repeat (4) @(negedge clk);
    wr(3, 4'hF, 32'h01);
    wr(4, 4'hF, 32'h02);
    @(negedge clk);
    gpio_in = 8'h3D;
    repeat (2) @(negedge clk);
    check("irq_not_yet", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'd1);
    rd(5, r);
    check("status_03", r, 32'h03);
    wr(5, 4'hF, 32'h01);
    rd(5, r);
    check("status_02", r, 32'h02);
    check("irq_still", 32'(irq), 32'd1);

    // Clear of bit0 coincides with a freshly latched pin0 rise.
    gpio_in = 8'h3C;
    repeat (4) @(negedge clk);
    gpio_in = 8'h3D;
    @(negedge clk);
    wr(5, 4'hF, 32'h01);
    rd(5, r);
    check("event_wins", r, 32'h03);

    // Miss, alias, and mid-access reset.
    iomem_valid = 1'b1; iomem_addr = 32'h0400_0000; iomem_wstrb = 4'hF; iomem_wdata = 32'h0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (iomem_ready) acks++;
    end
    iomem_valid = 1'b0;
    check("miss_acks", 32'(acks), 32'd0);
    check("miss_out", 32'(gpio_out), 32'h2E);
    bus(32'h03AB_CDE0, 4'hF, 32'h55, r);
    check("alias_wr", 32'(gpio_out), 32'h55);
    bus(32'h0300_0020, 4'h0, 32'h0, r);
    check("alias_rd", r, 32'h55);

    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = 32'h0300_0004; iomem_wstrb = 4'hF; iomem_wdata = 32'h0F;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("arst_ready", 32'(iomem_ready), 32'd0);
    check("arst_out",   32'(gpio_out),    32'd0);
    check("arst_oe",    32'(gpio_oe),     32'd0);
    check("arst_irq",   32'(irq),         32'd0);
    iomem_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    rd(5, r);
    check("arst_status", r, 32'h0);

    // Randomised traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      iomem_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0)
        iomem_addr = {8'h04 + 8'($urandom_range(0, 3)), 24'($urandom)};
      else
        iomem_addr = {8'h03, 24'($urandom)};
      iomem_wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      iomem_wdata = $urandom;
      if ($urandom_range(0, 3) == 0) gpio_in = W'($urandom);
    end
    @(negedge clk);
    iomem_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
